sr_latch_arbiter: RTL and testbench
===================================

# sr_latch_arbiter

Shares one bank of gated SR latches between two requesters. Each requester asks to set or clear one latch bit. The block arbitrates round-robin and sequences the latch drive as setup → gate strobe → hold. Its drive sequence never asserts S and R together on any bit, so the forbidden S=R=1 latch state is unreachable from this path. It sits between software-facing control logic and the latch bank and is the only driver of the bank's s/r/gate inputs.

## Interface
- NBITS, 8, number of latch bits in the bank
- IDXW, 3, index width; must satisfy 2**IDXW ≥ NBITS
- HOLD_CYC, 1, gate-high cycles per strobe (legal range 1..15)

- clk  in  1  single clock, rising-edge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- req_a_valid / req_b_valid  in  1  request pending; held high until the matching ack
- req_a_idx / req_b_idx  in  IDXW  target bit
- req_a_op / req_b_op  in  2  01 = clear, 10 = set, 00 and 11 = illegal
- ack_a / ack_b  out  1  one-cycle completion pulse
- err_a / err_b  out  1  pulses together with ack when the request was rejected
- lat_s, lat_r  out  NBITS  per-bit set/reset drive to the latch bank
- lat_g  out  1  latch gate; the latch is transparent while high
- busy  out  1  high in every state except IDLE
- shadow_q  out  NBITS  last value written per bit (only present with the macro; see Configuration)

## Operation
- All outputs are registered. The reset value of every output is 0.
- Internal reset state: FSM in IDLE, last-grant = B, so A wins the first contention.
- Arbitration happens in IDLE only.
  - One requester valid: grant it.
  - Both valid: grant the requester that was not granted last.
  - On grant, capture idx, op and the requester ID. After that, request inputs are ignored until the ack.
- Request legality: legal iff op ∈ {01, 10} and idx < NBITS.
- FSM states and transitions:
  - IDLE → SETUP on grant of a legal request.
  - IDLE → REJECT on grant of an illegal request.
  - SETUP: drive lat_s or lat_r one-hot at idx; lat_g = 0. Lasts 1 cycle, then STROBE.
  - STROBE: s/r held; lat_g = 1 for HOLD_CYC cycles, counted by an internal down-counter. Then RELEASE.
  - RELEASE: lat_g = 0; s/r still held for hold time; ack of the granted requester = 1. Lasts 1 cycle, then IDLE.
  - REJECT: ack = 1 and err = 1 for the granted requester; the latch is never driven. Lasts 1 cycle, then IDLE.
- On entering IDLE, lat_s and lat_r return to 0.
- Invariant: lat_s & lat_r == 0 on every cycle.
- Invariant: lat_g rises only when s/r have been stable for at least 1 cycle.
- A requester that is still valid in the cycle after its ack is treated as a new request.
- Reset mid-operation: lat_g, lat_s and lat_r drop asynchronously. No ack is issued for the aborted request, and the requester must re-request.

## Timing
- Legal request, no contention: grant at edge 0; SETUP cycle 1; STROBE cycles 2..1+HOLD_CYC; ack in cycle 2+HOLD_CYC.
  - Latency = HOLD_CYC+2 cycles from valid to ack.
- Illegal request: ack and err in cycle 1.
- Back-to-back: the next grant is evaluated in the IDLE cycle that follows RELEASE or REJECT.
  - Sustained throughput is one op per HOLD_CYC+3 cycles.
  - Under contention the grants alternate A, B, A, …

## Configuration
- SR_ARB_SHADOW_EN defined:
  - A NBITS shadow register tracks the written value of each bit and drives shadow_q. It resets to 0, which requires the latch bank to share this reset.
  - The shadow bit updates in RELEASE.
  - A legal request that would not change its bit (set on 1, clear on 0) skips the drive: IDLE → RELEASE directly, with ack (no err) in cycle 1 and no lat_s/lat_r/lat_g activity.
- SR_ARB_SHADOW_EN undefined: no shadow register, the shadow_q port is absent, and every legal request runs the full sequence.

## Structure
- Package sr_arb_pkg holds:
  - the state enum (IDLE, SETUP, STROBE, RELEASE, REJECT);
  - the op encodings OP_CLR = 2'b01 and OP_SET = 2'b10;
  - the requester-ID type.
- Sub-module rr_arb2: two-input round-robin arbiter with last-grant state. It is instantiated once and advances only on a grant.

## Test plan
- A set idx 3 alone → lat_s = 8'h08 from cycle 1; lat_g = 1 in cycle 2; ack_a in cycle 3; lat_r stays 0 throughout.
- A and B both valid in the first cycle after reset (A: set 0, B: clear 5) → A acked first; B's SETUP starts in the cycle after A's IDLE; acks alternate across 4 repeated pairs.
- A op 2'b11, and separately A idx 6 with NBITS = 6 → ack_a and err_a in cycle 1; lat_s, lat_r and lat_g never toggle.
- Reset low during STROBE of a set on bit 2 → lat_g, lat_s, lat_r, busy and ack go to 0 asynchronously; after release, A's re-request of set 2 completes normally.
- With SR_ARB_SHADOW_EN: set bit 4 twice → the first completes in 3 cycles and shadow_q = 8'h10; the second acks in cycle 1 with no strobe.
- HOLD_CYC = 3 → lat_g is high for exactly 3 cycles; ack arrives 5 cycles after valid; lat_s & lat_r == 0 is asserted on every cycle of every test.

Source files
------------

// File: rtl/sr_arb_pkg.sv
// Shared types and encodings for the SR-latch arbiter and its round-robin
// sub-arbiter.
package sr_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    RELEASE = 3'd3,
    REJECT  = 3'd4
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_SET = 2'b10;

  function automatic logic op_is_legal(input logic [1:0] op);
    return (op == OP_CLR) || (op == OP_SET);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; last-grant state advances only on a grant.
module rr_arb2
  import sr_arb_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    enable,
  input  logic    req_a,
  input  logic    req_b,
  output logic    gnt_valid,
  output req_id_t gnt_id
);

  req_id_t last_q;

  // NOTE: every variable gets a value before any branch, so no latch is inferred.
  always_comb begin
    gnt_valid = enable && (req_a || req_b);
    gnt_id    = REQ_B;
    if (req_a && req_b) gnt_id = (last_q == REQ_B) ? REQ_A : REQ_B;
    else if (req_a)     gnt_id = REQ_A;
  end

  // Starting from B makes A the winner of the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         last_q <= REQ_B;
    else if (gnt_valid) last_q <= gnt_id;
  end

endmodule

// File: rtl/sr_latch_arbiter.sv
// Shares one gated SR latch bank between two requesters; sequences
// setup -> strobe -> hold. Optional shadow register: SR_ARB_SHADOW_EN.
module sr_latch_arbiter
  import sr_arb_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int IDXW     = 3,
  parameter int HOLD_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a_valid,
  input  logic [IDXW-1:0]  req_a_idx,
  input  logic [1:0]       req_a_op,
  input  logic             req_b_valid,
  input  logic [IDXW-1:0]  req_b_idx,
  input  logic [1:0]       req_b_op,
  output logic             ack_a,
  output logic             ack_b,
  output logic             err_a,
  output logic             err_b,
  output logic [NBITS-1:0] lat_s,
  output logic [NBITS-1:0] lat_r,
  output logic             lat_g,
`ifdef SR_ARB_SHADOW_EN
  output logic [NBITS-1:0] shadow_q,
`endif
  output logic             busy
);

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC - 1);

  state_t          state, next_state;
  logic            gnt_valid;
  req_id_t         gnt_id;
  logic [IDXW-1:0] idx_q, cur_idx;
  logic [1:0]      op_q, cur_op;
  req_id_t         id_q, cur_id;
  logic            cur_legal, cur_skip;
  logic [3:0]      cnt_q;

  logic [NBITS-1:0] s_d, r_d;
  logic             g_d, busy_d, ack_a_d, ack_b_d, err_a_d, err_b_d;
  logic             drive, done;

  rr_arb2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .enable    (state == IDLE),
    .req_a     (req_a_valid),
    .req_b     (req_b_valid),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // In IDLE the live granted request is used; afterwards the captured copy,
  // so the registered outputs can be decoded from next_state.
  always_comb begin
    cur_id  = id_q;
    cur_idx = idx_q;
    cur_op  = op_q;
    if (state == IDLE) begin
      cur_id  = gnt_id;
      cur_idx = (gnt_id == REQ_A) ? req_a_idx : req_b_idx;
      cur_op  = (gnt_id == REQ_A) ? req_a_op  : req_b_op;
    end
    cur_legal = op_is_legal(cur_op) && (32'(cur_idx) < 32'(NBITS));
  end

`ifdef SR_ARB_SHADOW_EN
  logic [NBITS-1:0] shadow_r;
  logic             skip_q;
  logic             same_value;

  assign same_value = shadow_r[cur_idx] == (cur_op == OP_SET);
  assign cur_skip   = (state == IDLE) ? (cur_legal && same_value) : skip_q;
  assign shadow_q   = shadow_r;

  // NOTE: the shadow is reset with everything else; the latch bank must share this reset to stay coherent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_r <= '0;
      skip_q   <= 1'b0;
    end else begin
      if (state == IDLE)         skip_q <= cur_skip;
      if (next_state == RELEASE) shadow_r[cur_idx] <= (cur_op == OP_SET);
    end
  end
`else
  assign cur_skip = 1'b0;
`endif

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (gnt_valid) next_state = !cur_legal ? REJECT :
                                           (cur_skip ? RELEASE : SETUP);
      SETUP:   next_state = STROBE;
      STROBE:  if (cnt_q == '0) next_state = RELEASE;
      RELEASE: next_state = IDLE;
      REJECT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // S and R come from one op decode, so they can never be high together.
  always_comb begin
    drive   = (next_state == SETUP) || (next_state == STROBE) ||
              ((next_state == RELEASE) && !cur_skip);
    done    = (next_state == RELEASE) || (next_state == REJECT);
    s_d     = (drive && cur_op == OP_SET) ? (NBITS'(1) << cur_idx) : '0;
    r_d     = (drive && cur_op == OP_CLR) ? (NBITS'(1) << cur_idx) : '0;
    g_d     = (next_state == STROBE);
    busy_d  = (next_state != IDLE);
    ack_a_d = done && (cur_id == REQ_A);
    ack_b_d = done && (cur_id == REQ_B);
    err_a_d = (next_state == REJECT) && (cur_id == REQ_A);
    err_b_d = (next_state == REJECT) && (cur_id == REQ_B);
  end

  // NOTE: non-blocking assignments make every register sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      lat_s <= '0;
      lat_r <= '0;
      lat_g <= 1'b0;
      busy  <= 1'b0;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      err_a <= 1'b0;
      err_b <= 1'b0;
    end else begin
      state <= next_state;
      lat_s <= s_d;
      lat_r <= r_d;
      lat_g <= g_d;
      busy  <= busy_d;
      ack_a <= ack_a_d;
      ack_b <= ack_b_d;
      err_a <= err_a_d;
      err_b <= err_b_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= '0;
      op_q  <= '0;
      id_q  <= REQ_A;
      cnt_q <= '0;
    end else begin
      if (gnt_valid) begin
        idx_q <= cur_idx;
        op_q  <= cur_op;
        id_q  <= cur_id;
      end
      if (next_state == STROBE && state != STROBE) cnt_q <= HOLD_LOAD;
      else if (state == STROBE && cnt_q != '0)     cnt_q <= cnt_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_sr_latch_arbiter.sv
// Directed bench for sr_latch_arbiter: a default instance plus one with
// NBITS=6, HOLD_CYC=3; shadow checks follow SR_ARB_SHADOW_EN.
module tb_sr_latch_arbiter;
  import sr_arb_pkg::*;

  localparam logic [1:0] OP_BAD = 2'b11;
`ifdef SR_ARB_SHADOW_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 4;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid, b_valid;
  logic [2:0] a_idx, b_idx;
  logic [1:0] a_op, b_op;
  logic       ack_a, ack_b, err_a, err_b, lat_g, busy;
  logic [7:0] lat_s, lat_r;

  logic       v1;
  logic [2:0] idx1;
  logic [1:0] op1;
  logic       ack1, err1, ack1b, err1b, g1, busy1;
  logic [5:0] s1, r1;
`ifdef SR_ARB_SHADOW_EN
  logic [7:0] shadow_q;
  logic [5:0] shadow1;
`endif

  int tests = 0;
  int fails = 0;

  sr_latch_arbiter dut0 (
    .clk(clk), .reset(reset),
    .req_a_valid(a_valid), .req_a_idx(a_idx), .req_a_op(a_op),
    .req_b_valid(b_valid), .req_b_idx(b_idx), .req_b_op(b_op),
    .ack_a(ack_a), .ack_b(ack_b), .err_a(err_a), .err_b(err_b),
    .lat_s(lat_s), .lat_r(lat_r), .lat_g(lat_g),
`ifdef SR_ARB_SHADOW_EN
    .shadow_q(shadow_q),
`endif
    .busy(busy)
  );

  sr_latch_arbiter #(.NBITS(6), .IDXW(3), .HOLD_CYC(3)) dut1 (
    .clk(clk), .reset(reset),
    .req_a_valid(v1), .req_a_idx(idx1), .req_a_op(op1),
    .req_b_valid(1'b0), .req_b_idx(3'd0), .req_b_op(2'b00),
    .ack_a(ack1), .ack_b(ack1b), .err_a(err1), .err_b(err1b),
    .lat_s(s1), .lat_r(r1), .lat_g(g1),
`ifdef SR_ARB_SHADOW_EN
    .shadow_q(shadow1),
`endif
    .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int max_cyc, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(ack_a || ack_b) && n < max_cyc);
  endtask

  task automatic do_reset();
    a_valid = 0; b_valid = 0; v1 = 0;
    a_idx = 0; b_idx = 0; idx1 = 0;
    a_op = 0; b_op = 0; op1 = 0;
    reset = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
  endtask

  // Invariants on every cycle: S/R never overlap, gate rises only on stable S/R.
  logic [7:0] s0_prev, r0_prev;
  logic [5:0] s1_prev, r1_prev;
  logic       g0_prev, g1_prev;
  always @(negedge clk) begin
    check("inv_sr_dut0", 32'(lat_s & lat_r), 0);
    check("inv_sr_dut1", 32'(s1 & r1), 0);
    if (lat_g && !g0_prev)
      check("g_rise_dut0", 32'(((s0_prev | r0_prev) != 0) && s0_prev == lat_s && r0_prev == lat_r), 1);
    if (g1 && !g1_prev)
      check("g_rise_dut1", 32'(((s1_prev | r1_prev) != 0) && s1_prev == s1 && r1_prev == r1), 1);
    s0_prev <= lat_s; r0_prev <= lat_r; g0_prev <= lat_g;
    s1_prev <= s1;    r1_prev <= r1;    g1_prev <= g1;
  end

  initial begin
    int n;
    do_reset();
    // Reset state (reset has just been released, no edge since).
    check("rst_s", lat_s, 0);
    check("rst_r", lat_r, 0);
    check("rst_g", lat_g, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", {ack_a, ack_b, err_a, err_b}, 0);

    // A sets bit 3, no contention.
    a_valid = 1; a_idx = 3; a_op = OP_SET;
    tick();
    check("t1_c1_s", lat_s, 8'h08); check("t1_c1_g", lat_g, 0);
    check("t1_c1_r", lat_r, 0);     check("t1_c1_busy", busy, 1);
    check("t1_c1_ack", ack_a, 0);
    tick();
    check("t1_c2_g", lat_g, 1); check("t1_c2_s", lat_s, 8'h08);
    check("t1_c2_r", lat_r, 0); check("t1_c2_ack", ack_a, 0);
    tick();
    check("t1_c3_ack", ack_a, 1); check("t1_c3_err", err_a, 0);
    check("t1_c3_g", lat_g, 0);   check("t1_c3_s", lat_s, 8'h08);
    check("t1_c3_r", lat_r, 0);
    a_valid = 0;
    tick();
    check("t1_c4_s", lat_s, 0); check("t1_c4_ack", ack_a, 0);
    check("t1_c4_busy", busy, 0);

    // Contention right after reset: A set 0, B clear 5, held valid.
    do_reset();
    a_valid = 1; a_idx = 0; a_op = OP_SET;
    b_valid = 1; b_idx = 5; b_op = OP_CLR;
    tick(); tick(); tick();
    check("t2_c3_ack_a", ack_a, 1); check("t2_c3_ack_b", ack_b, 0);
    tick();
    check("t2_c4_busy", busy, 0); check("t2_c4_s", lat_s, 0);
    tick();
`ifdef SR_ARB_SHADOW_EN
    check("t2_c5_ack_b", ack_b, 1); check("t2_c5_r", lat_r, 0);
    check("t2_c5_g", lat_g, 0);
`else
    check("t2_c5_r", lat_r, 8'h20); check("t2_c5_s", lat_s, 0);
    check("t2_c5_g", lat_g, 0);
    tick();
    check("t2_c6_g", lat_g, 1);
    tick();
    check("t2_c7_ack_b", ack_b, 1); check("t2_c7_ack_a", ack_a, 0);
`endif
    for (int i = 2; i < 8; i++) begin
      wait_ack(20, n);
      check("t2_ack_seen", 32'(ack_a || ack_b), 1);
      check("t2_ack_a", 32'(ack_a), 32'(i % 2 == 0));
      check("t2_ack_b", 32'(ack_b), 32'(i % 2 == 1));
      check("t2_gap", n, GAP);
    end
    a_valid = 0; b_valid = 0;
    tick();

    // Illegal op on A (dut0), then out-of-range idx on dut1 (NBITS=6).
    do_reset();
    a_valid = 1; a_idx = 1; a_op = OP_BAD;
    tick();
    check("t3_c1_ack", ack_a, 1); check("t3_c1_err", err_a, 1);
    check("t3_c1_lat", {lat_s, lat_r, 7'd0, lat_g}, 0);
    check("t3_c1_busy", busy, 1);
    a_valid = 0;
    tick();
    check("t3_c2_ack", {ack_a, err_a}, 0); check("t3_c2_busy", busy, 0);
    check("t3_c2_lat", {lat_s, lat_r, 7'd0, lat_g}, 0);
    v1 = 1; idx1 = 6; op1 = OP_SET;
    tick();
    check("t3_idx_ack", ack1, 1); check("t3_idx_err", err1, 1);
    check("t3_idx_lat", {s1, r1, 5'd0, g1}, 0);
    v1 = 0;
    tick();
    check("t3_idx_c2", {ack1, err1, busy1}, 0);
    check("t3_idx_c2_lat", {s1, r1, 5'd0, g1}, 0);

    // Reset asserted during STROBE of set bit 2, then re-request.
    do_reset();
    a_valid = 1; a_idx = 2; a_op = OP_SET;
    tick();
    check("t4_c1_s", lat_s, 8'h04);
    tick();
    check("t4_c2_g", lat_g, 1);
    #2 reset = 1'b0; a_valid = 0;
    #1;
    check("t4_async_g", lat_g, 0);    check("t4_async_s", lat_s, 0);
    check("t4_async_r", lat_r, 0);    check("t4_async_busy", busy, 0);
    check("t4_async_ack", {ack_a, ack_b}, 0);
    @(posedge clk);
    #3 reset = 1'b1;
    a_valid = 1; a_idx = 2; a_op = OP_SET;
    tick();
    check("t4_re_c1_s", lat_s, 8'h04); check("t4_re_c1_g", lat_g, 0);
    tick();
    check("t4_re_c2_g", lat_g, 1);
    tick();
    check("t4_re_c3_ack", ack_a, 1); check("t4_re_c3_err", err_a, 0);
    a_valid = 0;
    tick();

`ifdef SR_ARB_SHADOW_EN
    // Set bit 4 twice: second request is a no-change skip.
    do_reset();
    a_valid = 1; a_idx = 4; a_op = OP_SET;
    tick(); tick(); tick();
    check("t5_c3_ack", ack_a, 1);
    a_valid = 0;
    tick();
    check("t5_shadow", shadow_q, 8'h10);
    a_valid = 1;
    tick();
    check("t5_skip_ack", ack_a, 1); check("t5_skip_err", err_a, 0);
    check("t5_skip_lat", {lat_s, lat_r, 7'd0, lat_g}, 0);
    a_valid = 0;
    tick();
    check("t5_skip_done", {ack_a, busy}, 0);
    check("t5_shadow2", shadow_q, 8'h10);
`endif

    // HOLD_CYC = 3 on dut1: gate high for exactly 3 cycles, ack 5 cycles after valid.
    do_reset();
    v1 = 1; idx1 = 1; op1 = OP_SET;
    tick();
    check("t6_c1_g", g1, 0); check("t6_c1_s", s1, 6'h02);
    tick(); check("t6_c2_g", g1, 1);
    tick(); check("t6_c3_g", g1, 1);
    tick(); check("t6_c4_g", g1, 1); check("t6_c4_ack", ack1, 0);
    tick();
    check("t6_c5_g", g1, 0); check("t6_c5_ack", ack1, 1);
    check("t6_c5_b", {ack1b, err1b, err1}, 0);
    v1 = 0;
    tick();
    check("t6_c6_busy", busy1, 0); check("t6_c6_s", s1, 0);
`ifdef SR_ARB_SHADOW_EN
    check("t6_shadow", shadow1, 6'h02);
`endif

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
